// File: rtl/data_sram_responder.sv
// Data-side SRAM responder: byte-writable word array with a configurable read latency.
// Optional misaligned-access detection is compiled in with `define DSRAM_ALIGN_CHECK_EN.
module data_sram_responder #(
  parameter int unsigned DEPTH_LOG2 = 10,
  parameter int unsigned LATENCY    = 1
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        data_sram_en,
  input  logic [3:0]  data_sram_wen,
  input  logic [31:0] data_sram_addr,
  input  logic [31:0] data_sram_wdata,
  output logic [31:0] data_sram_rdata,
  output logic        resp_valid,
  output logic        stallreq
`ifdef DSRAM_ALIGN_CHECK_EN
  ,
  output logic        align_err
`endif
);

  localparam int unsigned DEPTH = 1 << DEPTH_LOG2;
  localparam int unsigned CNT_W = 4;

  typedef enum logic {IDLE, BUSY} state_t;

  logic [31:0]           r_mem [DEPTH];
  state_t                r_state, w_state_nxt;
  logic [CNT_W-1:0]      r_cnt, w_cnt_nxt;
  logic [31:0]           r_rdata, w_rdata_nxt;
  logic [31:0]           r_sample, w_sample_nxt;
  logic                  r_resp, w_resp_nxt;
  logic [DEPTH_LOG2-1:0] w_idx;
  logic                  w_misalign;
  logic                  w_accept;
  logic                  w_write;
  logic                  w_read;
  logic                  w_unused;

  assign w_idx    = data_sram_addr[DEPTH_LOG2+1:2];
  assign w_unused = &{1'b0, data_sram_addr[31:DEPTH_LOG2+2], data_sram_addr[1:0]};

`ifdef DSRAM_ALIGN_CHECK_EN
  logic r_align_err;

  assign w_misalign =
      (((data_sram_wen == 4'b0000) || (data_sram_wen == 4'b1111)) && (data_sram_addr[1:0] != 2'b00)) ||
      (((data_sram_wen == 4'b0011) || (data_sram_wen == 4'b1100)) && data_sram_addr[0]);

  // Flag is raised only for requests that would otherwise have been accepted
  always_ff @(posedge clk) begin
    if (rst) r_align_err <= 1'b0;
    else     r_align_err <= data_sram_en && (r_state == IDLE) && w_misalign;
  end

  assign align_err = r_align_err;
`else
  assign w_misalign = 1'b0;
`endif

  assign w_accept = data_sram_en && (r_state == IDLE) && !w_misalign && !rst;
  assign w_write  = w_accept && (|data_sram_wen);
  assign w_read   = w_accept && (data_sram_wen == 4'b0000);

  // Byte-lane write commits at the accept edge, so later reads need no bypass
  always_ff @(posedge clk) begin
    if (w_write) begin
      for (int i = 0; i < 4; i++) begin
        if (data_sram_wen[i]) r_mem[w_idx][8*i +: 8] <= data_sram_wdata[8*i +: 8];
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= IDLE;
      r_cnt    <= '0;
      r_rdata  <= '0;
      r_sample <= '0;
      r_resp   <= 1'b0;
    end else begin
      r_state  <= w_state_nxt;
      r_cnt    <= w_cnt_nxt;
      r_rdata  <= w_rdata_nxt;
      r_sample <= w_sample_nxt;
      r_resp   <= w_resp_nxt;
    end
  end

  always_comb begin
    w_state_nxt  = r_state;
    w_cnt_nxt    = r_cnt;
    w_rdata_nxt  = r_rdata;
    w_sample_nxt = r_sample;
    w_resp_nxt   = 1'b0;
    unique case (r_state)
      IDLE: begin
        if (w_read) begin
          if (LATENCY <= 1) begin
            w_rdata_nxt = r_mem[w_idx];
            w_resp_nxt  = 1'b1;
          end else begin
            w_sample_nxt = r_mem[w_idx];
            w_cnt_nxt    = CNT_W'(LATENCY - 1);
            w_state_nxt  = BUSY;
          end
        end
      end
      BUSY: begin
        w_cnt_nxt = r_cnt - CNT_W'(1);
        // Counter hitting zero delivers the word captured at accept time
        if (w_cnt_nxt == '0) begin
          w_rdata_nxt = r_sample;
          w_resp_nxt  = 1'b1;
          w_state_nxt = IDLE;
        end
      end
      default: w_state_nxt = IDLE;
    endcase
  end

  assign data_sram_rdata = r_rdata;
  assign resp_valid      = r_resp;
  assign stallreq        = (r_state == BUSY);

endmodule

// File: tb/tb_data_sram_responder.sv
// Directed bench for data_sram_responder: three instances at LATENCY 1, 3 and 4.
// Alignment checks are exercised when DSRAM_ALIGN_CHECK_EN is defined.
module tb_data_sram_responder;

  logic        clk;
  logic        rst;
  logic        en1, en3, en4;
  logic [3:0]  wen;
  logic [31:0] addr;
  logic [31:0] wdata;
  logic [31:0] rdata1, rdata3, rdata4;
  logic        resp1, resp3, resp4;
  logic        stall1, stall3, stall4;
`ifdef DSRAM_ALIGN_CHECK_EN
  logic        align1, align3, align4;
`endif

  int n_checks = 0;
  int n_errors = 0;
  int lat;

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(1)) u_l1 (
    .clk(clk), .rst(rst), .data_sram_en(en1), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata1),
    .resp_valid(resp1), .stallreq(stall1)
`ifdef DSRAM_ALIGN_CHECK_EN
    , .align_err(align1)
`endif
  );

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(3)) u_l3 (
    .clk(clk), .rst(rst), .data_sram_en(en3), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata3),
    .resp_valid(resp3), .stallreq(stall3)
`ifdef DSRAM_ALIGN_CHECK_EN
    , .align_err(align3)
`endif
  );

  data_sram_responder #(.DEPTH_LOG2(10), .LATENCY(4)) u_l4 (
    .clk(clk), .rst(rst), .data_sram_en(en4), .data_sram_wen(wen),
    .data_sram_addr(addr), .data_sram_wdata(wdata), .data_sram_rdata(rdata4),
    .resp_valid(resp4), .stallreq(stall4)
`ifdef DSRAM_ALIGN_CHECK_EN
    , .align_err(align4)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  // Drive one cycle of request inputs; returns at the next falling edge.
  // ens bit 0 -> LATENCY 1, bit 1 -> LATENCY 3, bit 2 -> LATENCY 4
  task automatic cyc(input logic [2:0] ens, input logic [3:0] w,
                     input logic [31:0] a, input logic [31:0] d);
    en1   = ens[0];
    en3   = ens[1];
    en4   = ens[2];
    wen   = w;
    addr  = a;
    wdata = d;
    @(negedge clk);
  endtask

  initial begin
    #100000;
    $display("FAIL timeout: got %0d expected %0d", 0, 1);
    $fatal(1);
  end

  initial begin
    rst = 1'b1;
    en1 = 1'b0; en3 = 1'b0; en4 = 1'b0;
    wen = '0; addr = '0; wdata = '0;
    @(negedge clk);
    @(negedge clk);
    check("rst_rdata1", rdata1, 32'h0);
    check("rst_resp1", 32'(resp1), 32'h0);
    check("rst_stall1", 32'(stall1), 32'h0);
    check("rst_stall3", 32'(stall3), 32'h0);
    check("rst_rdata4", rdata4, 32'h0);
    check("rst_stall4", 32'(stall4), 32'h0);
    rst = 1'b0;

    // LATENCY=1 full-word write then read
    cyc(3'b001, 4'hF, 32'h10, 32'hDEADBEEF);
    check("l1_wr_stall", 32'(stall1), 32'h0);
    check("l1_wr_resp", 32'(resp1), 32'h0);
    cyc(3'b001, 4'h0, 32'h10, 32'h0);
    check("l1_rd_data", rdata1, 32'hDEADBEEF);
    check("l1_rd_resp", 32'(resp1), 32'h1);
    check("l1_rd_stall", 32'(stall1), 32'h0);
    cyc(3'b000, 4'h0, 32'h0, 32'h0);
    check("l1_resp_pulse", 32'(resp1), 32'h0);
    check("l1_rdata_hold", rdata1, 32'hDEADBEEF);

    // Partial byte writes
    cyc(3'b001, 4'b0010, 32'h10, 32'h0000AA00);
    cyc(3'b001, 4'h0, 32'h10, 32'h0);
    check("l1_byte1", rdata1, 32'hDEADAAEF);
    cyc(3'b001, 4'b1000, 32'h10, 32'h11000000);
    cyc(3'b001, 4'h0, 32'h10, 32'h0);
    check("l1_byte3", rdata1, 32'h11ADAAEF);

    // Back-to-back reads, one per cycle
    cyc(3'b001, 4'hF, 32'h14, 32'h55AA55AA);
    cyc(3'b001, 4'h0, 32'h14, 32'h0);
    check("l1_b2b_a", rdata1, 32'h55AA55AA);
    check("l1_b2b_a_resp", 32'(resp1), 32'h1);
    cyc(3'b001, 4'h0, 32'h10, 32'h0);
    check("l1_b2b_b", rdata1, 32'h11ADAAEF);
    check("l1_b2b_b_resp", 32'(resp1), 32'h1);
    cyc(3'b000, 4'h0, 32'h0, 32'h0);
    check("l1_b2b_end", 32'(resp1), 32'h0);

    // Address aliasing modulo 4 KiB
    cyc(3'b001, 4'hF, 32'h00001000, 32'hCAFEF00D);
    cyc(3'b001, 4'h0, 32'h00000000, 32'h0);
    check("l1_alias", rdata1, 32'hCAFEF00D);

    // LATENCY=3 read with an ignored write during the stall
    cyc(3'b010, 4'hF, 32'h20, 32'h12345678);
    check("l3_wr_nostall", 32'(stall3), 32'h0);
    cyc(3'b010, 4'h0, 32'h20, 32'h0);
    check("l3_c1_stall", 32'(stall3), 32'h1);
    check("l3_c1_resp", 32'(resp3), 32'h0);
    cyc(3'b010, 4'hF, 32'h20, 32'hFFFFFFFF);
    check("l3_c2_stall", 32'(stall3), 32'h1);
    check("l3_c2_resp", 32'(resp3), 32'h0);
    cyc(3'b000, 4'h0, 32'h0, 32'h0);
    check("l3_c3_stall", 32'(stall3), 32'h0);
    check("l3_c3_resp", 32'(resp3), 32'h1);
    check("l3_c3_data", rdata3, 32'h12345678);
    cyc(3'b010, 4'h0, 32'h20, 32'h0);
    lat = 1;
    while (!resp3 && lat < 12) begin
      cyc(3'b000, 4'h0, 32'h0, 32'h0);
      lat++;
    end
    check("l3_reread_lat", 32'(lat), 32'd3);
    check("l3_reread_data", rdata3, 32'h12345678);

    // LATENCY=4 read abandoned by reset
    cyc(3'b100, 4'hF, 32'h30, 32'hA5A5A5A5);
    cyc(3'b100, 4'h0, 32'h30, 32'h0);
    check("l4_c1_stall", 32'(stall4), 32'h1);
    cyc(3'b000, 4'h0, 32'h0, 32'h0);
    check("l4_c2_stall", 32'(stall4), 32'h1);
    rst = 1'b1;
    cyc(3'b000, 4'h0, 32'h0, 32'h0);
    rst = 1'b0;
    check("l4_rst_stall", 32'(stall4), 32'h0);
    check("l4_rst_rdata", rdata4, 32'h0);
    check("l4_rst_resp", 32'(resp4), 32'h0);
    for (int i = 0; i < 4; i++) begin
      cyc(3'b000, 4'h0, 32'h0, 32'h0);
      check("l4_no_resp", 32'(resp4), 32'h0);
    end
    cyc(3'b100, 4'h0, 32'h30, 32'h0);
    lat = 1;
    while (!resp4 && lat < 12) begin
      check("l4_post_stall", 32'(stall4), 32'h1);
      cyc(3'b000, 4'h0, 32'h0, 32'h0);
      lat++;
    end
    check("l4_post_lat", 32'(lat), 32'd4);
    check("l4_post_data", rdata4, 32'hA5A5A5A5);
    check("l4_post_stall_end", 32'(stall4), 32'h0);

`ifdef DSRAM_ALIGN_CHECK_EN
    cyc(3'b001, 4'hF, 32'h20, 32'h01234567);
    check("al_ok_wr", 32'(align1), 32'h0);
    cyc(3'b001, 4'hF, 32'h22, 32'hFFFFFFFF);
    check("al_err", 32'(align1), 32'h1);
    check("al_err_resp", 32'(resp1), 32'h0);
    cyc(3'b001, 4'h0, 32'h20, 32'h0);
    check("al_err_pulse", 32'(align1), 32'h0);
    check("al_prior", rdata1, 32'h01234567);
    cyc(3'b001, 4'b1100, 32'h22, 32'hBEEF0000);
    check("al_half_ok", 32'(align1), 32'h0);
    cyc(3'b001, 4'h0, 32'h20, 32'h0);
    check("al_half_data", rdata1, 32'hBEEF4567);
`endif

    cyc(3'b000, 4'h0, 32'h0, 32'h0);
    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
